reg_hazard_scoreboard: RTL and testbench
========================================

Name: reg_hazard_scoreboard

Overview:
- Scoreboard and stall controller for the ARM 5-stage pipeline's 15-entry register file (R0–R14).
- Tracks in-flight destination registers between ID and WB, and raises a stall when an ID-stage source reads a register that is not yet written.
- Sits beside the ID stage and drives the IF/ID freeze and the ID/EXE bubble.
- The register file writes on the falling clock edge, so WB-stage writers never cause a hazard.

Parameters:
- NUM_REGS, 15, number of architectural registers held in the register file.
- ADDR_W, 4, register index width.
- TRACK_DEPTH, 2, number of tracked in-flight stages (EXE, MEM).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- freeze  input  1  global pipeline hold (memory wait); scoreboard holds state
- flush  input  1  branch taken; the instruction in ID does not issue
- id_valid  input  1  ID holds a real instruction
- id_src1  input  ADDR_W  first source register index
- id_src2  input  ADDR_W  second source register index
- id_two_src  input  1  id_src2 is actually read (register operand or STR)
- id_wb_en  input  1  ID instruction writes a register
- id_dest  input  ADDR_W  ID destination index
- id_mem_read  input  1  ID instruction is LDR
- hazard  output  1  stall: hold PC and IF/ID, insert bubble into ID/EXE
- pending_mask  output  NUM_REGS  bit r set while R r has a tracked in-flight writer
- fwd_sel1  output  2  EXE operand-1 source: 00 regfile, 01 MEM result, 10 WB result
- fwd_sel2  output  2  same for operand 2

Behaviour:
- State is a shift chain of TRACK_DEPTH entries, each holding {valid, dest, mem_read}.
  - Entry 0 is EXE.
  - Entry TRACK_DEPTH-1 is MEM.
- Reset (rst=1 at posedge): all entries invalid, pending_mask=0, fwd_sel1=fwd_sel2=00. hazard reads 0 after reset.
- Source match conditions, evaluated against valid entries:
  - src1 matches when id_valid and src1 equals the entry's dest.
  - src2 matches when id_valid, id_two_src, and src2 equals the entry's dest.
  - Index 15 (PC) and any index ≥ NUM_REGS never match.
- hazard is combinational from current entries and ID inputs, forced to 0 when freeze=1.
- Issue = id_valid & id_wb_en & ~hazard & ~flush.
- Each posedge, when freeze=0:
  - Entry 0 loads {issue, id_dest, id_mem_read}.
  - Entry k loads entry k-1.
  - The last entry retires.
- Each posedge, when freeze=1: all entries, pending_mask and fwd_sel hold.
- An instruction with id_wb_en=0 still advances, as an invalid entry.
- hazard and flush together: flush wins, and a bubble enters.
- pending_mask is registered. It equals the OR of the one-hot dest of all valid entries after the update.
- Two entries with the same dest: the bit stays set until both have retired.
- rst asserted mid-stream clears all entries on the same edge, regardless of freeze.
- Latency: an ID instruction whose writer is in EXE stalls 2 cycles; a writer in MEM stalls 1 cycle.

Optional Feature:
- Macro: REG_HAZARD_FORWARDING_EN.
- When defined:
  - hazard asserts only for load-use, i.e. a match against entry 0 with mem_read=1. That gives a 1-cycle stall.
  - fwd_sel1 and fwd_sel2 are registered at issue; they travel with the instruction into EXE.
  - Encoding: 01 if the src matched entry 0, else 10 if it matched the last entry, else 00. The entry-0 match has priority.
- When undefined:
  - Full stall behaviour as above.
  - fwd_sel1 and fwd_sel2 are tied to 00.

Decomposition:
- Package reg_hazard_pkg holds:
  - the ADDR_W and NUM_REGS constants;
  - the PC index constant (4'd15);
  - fwd_sel encodings FWD_REGFILE, FWD_MEM, FWD_WB;
  - a typedef for the scoreboard entry struct {valid, dest, mem_read}.
- One natural sub-module: reg_hazard_cmp. It takes one entry plus src1/src2/two_src and outputs the match bits. Instantiate it once per entry.

Test Plan:
- Reset, then ADD R1 (dest 1) issued, next cycle SUB reading src1=1 → hazard=1 for 2 cycles, pending_mask=0x0002, then hazard=0 and mask returns to 0 after retire.
- Writer dest 3, then an independent instruction, then a reader of src2=3 with id_two_src=1 → 1-cycle stall. Same reader with id_two_src=0 → no stall.
- Reader with src1=15 while a writer to R14 is in EXE → hazard=0.
- Hazard pending and freeze=1 for 3 cycles → entries hold, hazard=0 during freeze, stall resumes after release; flush with hazard → bubble, pending_mask unchanged by the flushed instruction.
- With REG_HAZARD_FORWARDING_EN:
  - LDR R2 followed by ADD src1=2 → exactly 1 stall cycle, then fwd_sel1=10.
  - ADD R4 followed by ORR src2=4 → no stall, fwd_sel2=01.
- rst pulsed while two entries are valid and freeze=1 → pending_mask=0 and hazard=0 next cycle.

Source files
------------

// File: rtl/reg_hazard_scoreboard_pkg.sv
// reg_hazard_pkg: constants, forwarding encodings and the scoreboard entry
// type shared by the register hazard scoreboard and its comparator.
package reg_hazard_pkg;

  localparam int NUM_REGS = 15;
  localparam int ADDR_W   = 4;

  localparam logic [ADDR_W-1:0] PC_IDX = 4'd15;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic              mem_read;
  } sb_entry_t;

  // One-hot pending bit for a valid entry; R15 and beyond have no bit.
  function automatic logic [NUM_REGS-1:0] dest_onehot(input sb_entry_t e);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (e.valid && (e.dest == ADDR_W'(r))) oh[r] = 1'b1;
    end
    return oh;
  endfunction

  // The youngest producer wins: EXE (its result is now in MEM) beats the older one.
  function automatic fwd_sel_e fwd_pick(input logic hit_exe, input logic hit_last);
    if (hit_exe)  return FWD_MEM;
    if (hit_last) return FWD_WB;
    return FWD_REGFILE;
  endfunction

endpackage

// File: rtl/reg_hazard_scoreboard_if.sv
// reg_hazard_scoreboard_if: ID-stage request side and stall/forward result
// side of the register hazard scoreboard. master = ID stage, slave = scoreboard.
interface reg_hazard_scoreboard_if;
  import reg_hazard_pkg::*;

  logic                freeze;
  logic                flush;
  logic                id_valid;
  logic [ADDR_W-1:0]   id_src1;
  logic [ADDR_W-1:0]   id_src2;
  logic                id_two_src;
  logic                id_wb_en;
  logic [ADDR_W-1:0]   id_dest;
  logic                id_mem_read;
  logic                hazard;
  logic [NUM_REGS-1:0] pending_mask;
  logic [1:0]          fwd_sel1;
  logic [1:0]          fwd_sel2;

  modport master (
    output freeze, flush, id_valid, id_src1, id_src2, id_two_src,
           id_wb_en, id_dest, id_mem_read,
    input  hazard, pending_mask, fwd_sel1, fwd_sel2
  );

  modport slave (
    input  freeze, flush, id_valid, id_src1, id_src2, id_two_src,
           id_wb_en, id_dest, id_mem_read,
    output hazard, pending_mask, fwd_sel1, fwd_sel2
  );

endinterface

// File: rtl/reg_hazard_scoreboard_cmp.sv
// reg_hazard_cmp: matches the ID-stage sources against one in-flight entry.
// The PC (R15) and any index past the register file never match.
module reg_hazard_cmp
  import reg_hazard_pkg::*;
(
  input  sb_entry_t         entry_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] src1_i,
  input  logic [ADDR_W-1:0] src2_i,
  input  logic              two_src_i,
  output logic              hit1_o,
  output logic              hit2_o,
  output logic              load_o
);

  logic dest_live;

  assign dest_live = entry_i.valid && (entry_i.dest != PC_IDX) &&
                     (int'(entry_i.dest) < NUM_REGS);

  assign hit1_o = id_valid_i && dest_live && (src1_i == entry_i.dest);
  assign hit2_o = id_valid_i && two_src_i && dest_live && (src2_i == entry_i.dest);
  assign load_o = entry_i.valid && entry_i.mem_read;

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// reg_hazard_scoreboard: tracks destination registers in flight between ID
// and WB (EXE, MEM) and stalls an ID instruction that reads one of them.
// WB writers are invisible because the register file writes on the falling edge.
// Optional macro REG_HAZARD_FORWARDING_EN: stall only on load-use and drive
// registered EXE operand forwarding selects.
module reg_hazard_scoreboard
  import reg_hazard_pkg::*;
#(
  parameter int TRACK_DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst,
  reg_hazard_scoreboard_if.slave sb
);

`ifdef REG_HAZARD_FORWARDING_EN
  localparam bit LOAD_USE_ONLY = 1'b1;
`else
  localparam bit LOAD_USE_ONLY = 1'b0;
`endif

  sb_entry_t [TRACK_DEPTH-1:0] ent_q, ent_d;
  logic [NUM_REGS-1:0]         mask_q, mask_d;
  logic [TRACK_DEPTH-1:0]      hit1, hit2, load, stall_vec;
  logic                        hazard, issue;

  for (genvar k = 0; k < TRACK_DEPTH; k++) begin : g_ent
    reg_hazard_cmp u_cmp (
      .entry_i    (ent_q[k]),
      .id_valid_i (sb.id_valid),
      .src1_i     (sb.id_src1),
      .src2_i     (sb.id_src2),
      .two_src_i  (sb.id_two_src),
      .hit1_o     (hit1[k]),
      .hit2_o     (hit2[k]),
      .load_o     (load[k])
    );
    // With forwarding only a load still in EXE cannot be bypassed.
    assign stall_vec[k] = (hit1[k] | hit2[k]) &
                          (LOAD_USE_ONLY ? ((k == 0) && load[k]) : 1'b1);
  end

  assign hazard          = (|stall_vec) & ~sb.freeze;
  assign issue           = sb.id_valid & sb.id_wb_en & ~hazard & ~sb.flush;
  assign sb.hazard       = hazard;
  assign sb.pending_mask = mask_q;

  // Shift the chain one stage and rebuild the pending mask from its new contents.
  always_comb begin
    ent_d    = ent_q;
    ent_d[0] = '{valid: issue, dest: sb.id_dest, mem_read: sb.id_mem_read};
    for (int k = 1; k < TRACK_DEPTH; k++) ent_d[k] = ent_q[k-1];
    mask_d = '0;
    for (int k = 0; k < TRACK_DEPTH; k++) mask_d = mask_d | dest_onehot(ent_d[k]);
  end

  // Reset clears everything, freeze holds, otherwise the chain advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q  <= '0;
      mask_q <= '0;
    end else if (!sb.freeze) begin
      ent_q  <= ent_d;
      mask_q <= mask_d;
    end
  end

`ifdef REG_HAZARD_FORWARDING_EN
  fwd_sel_e fwd1_q, fwd1_d, fwd2_q, fwd2_d;

  // Operand sources for the instruction entering EXE; a bubble reads the regfile.
  always_comb begin
    fwd1_d = FWD_REGFILE;
    fwd2_d = FWD_REGFILE;
    if (!hazard && !sb.flush) begin
      fwd1_d = fwd_pick(hit1[0], hit1[TRACK_DEPTH-1]);
      fwd2_d = fwd_pick(hit2[0], hit2[TRACK_DEPTH-1]);
    end
  end

  // Selects travel with the instruction into EXE and hold under freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd1_q <= FWD_REGFILE;
      fwd2_q <= FWD_REGFILE;
    end else if (!sb.freeze) begin
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
    end
  end

  assign sb.fwd_sel1 = fwd1_q;
  assign sb.fwd_sel2 = fwd2_q;
`else
  assign sb.fwd_sel1 = FWD_REGFILE;
  assign sb.fwd_sel2 = FWD_REGFILE;
`endif

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Testbench for reg_hazard_scoreboard: directed vector table followed by
// randomized traffic checked against an in-flight-list reference model.
module tb_reg_hazard_scoreboard;
  import reg_hazard_pkg::*;

  localparam int TD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_hazard_scoreboard_if sb_if ();

  reg_hazard_scoreboard #(.TRACK_DEPTH(TD)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  typedef struct {
    logic        rst, frz, fls, vld;
    logic [3:0]  s1, s2;
    logic        two, wb;
    logic [3:0]  dst;
    logic        ld;
    logic        exp_hz;
    logic [14:0] exp_mask;
    logic [1:0]  exp_f1, exp_f2;
  } vec_t;

  // Reference model: list of issued writers stamped with the advance count at issue.
  typedef struct {
    int dest;
    bit ld;
    int step;
  } fly_t;

  fly_t        fly[$];
  int          adv;
  logic [1:0]  mf1, mf2;
  int          total = 0;
  int          bad = 0;
  vec_t        tbl[$];

  function automatic vec_t mk(input logic r, f, fl, v, input logic [3:0] a, b,
                              input logic t, w, input logic [3:0] d, input logic l,
                              input logic hz, input logic [14:0] m,
                              input logic [1:0] e1, e2);
    vec_t x;
    x.rst = r; x.frz = f; x.fls = fl; x.vld = v; x.s1 = a; x.s2 = b;
    x.two = t; x.wb = w; x.dst = d; x.ld = l;
    x.exp_hz = hz; x.exp_mask = m; x.exp_f1 = e1; x.exp_f2 = e2;
    return x;
  endfunction

  function automatic bit reads(input int dest, input bit en, input logic [3:0] src);
    return en && (dest < NUM_REGS) && (dest == int'(src));
  endfunction

  function automatic bit hits(input fly_t f, input vec_t v);
    return reads(f.dest, v.vld, v.s1) || reads(f.dest, v.vld && v.two, v.s2);
  endfunction

  function automatic logic model_hazard(input vec_t v);
    logic h;
    h = 1'b0;
    if (v.frz) return 1'b0;
    foreach (fly[i]) begin
      if (hits(fly[i], v)) begin
`ifdef REG_HAZARD_FORWARDING_EN
        if ((adv - fly[i].step == 0) && fly[i].ld) h = 1'b1;
`else
        h = 1'b1;
`endif
      end
    end
    return h;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [3:0] src, input bit en);
    bit young, old;
    young = 0; old = 0;
    foreach (fly[i]) begin
      if (reads(fly[i].dest, en, src)) begin
        if (adv - fly[i].step == 0)      young = 1;
        if (adv - fly[i].step == TD - 1) old = 1;
      end
    end
    if (young) return 2'b01;
    if (old)   return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [14:0] model_mask();
    logic [14:0] m;
    m = '0;
    foreach (fly[i]) if (fly[i].dest < NUM_REGS) m[fly[i].dest] = 1'b1;
    return m;
  endfunction

  task automatic model_edge(input vec_t v, input logic hz);
    fly_t        keep[$];
    fly_t        n;
    logic [1:0]  e1, e2;
    if (v.rst) begin
      fly.delete();
      adv = 0;
      mf1 = 2'b00;
      mf2 = 2'b00;
    end else if (!v.frz) begin
      e1 = model_fwd(v.s1, v.vld);
      e2 = model_fwd(v.s2, v.vld && v.two);
      if (hz || v.fls) begin e1 = 2'b00; e2 = 2'b00; end
`ifdef REG_HAZARD_FORWARDING_EN
      mf1 = e1;
      mf2 = e2;
`else
      mf1 = 2'b00;
      mf2 = 2'b00;
`endif
      adv++;
      if (v.vld && v.wb && !hz && !v.fls) begin
        n.dest = int'(v.dst);
        n.ld   = v.ld;
        n.step = adv;
        fly.push_back(n);
      end
      foreach (fly[i]) if (adv - fly[i].step < TD) keep.push_back(fly[i]);
      fly = keep;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle at posedge+1, check hazard at negedge, check state after the edge.
  task automatic run_vec(input vec_t v, input bit use_tbl, input string tag);
    logic mhz;
    rst               = v.rst;
    sb_if.freeze      = v.frz;
    sb_if.flush       = v.fls;
    sb_if.id_valid    = v.vld;
    sb_if.id_src1     = v.s1;
    sb_if.id_src2     = v.s2;
    sb_if.id_two_src  = v.two;
    sb_if.id_wb_en    = v.wb;
    sb_if.id_dest     = v.dst;
    sb_if.id_mem_read = v.ld;
    @(negedge clk);
    mhz = model_hazard(v);
    chk({tag, "_hazard"}, 32'(sb_if.hazard), use_tbl ? 32'(v.exp_hz) : 32'(mhz));
    @(posedge clk);
    model_edge(v, mhz);
    #1;
    chk({tag, "_mask"}, 32'(sb_if.pending_mask),
        use_tbl ? 32'(v.exp_mask) : 32'(model_mask()));
    chk({tag, "_fwd1"}, 32'(sb_if.fwd_sel1), use_tbl ? 32'(v.exp_f1) : 32'(mf1));
    chk({tag, "_fwd2"}, 32'(sb_if.fwd_sel2), use_tbl ? 32'(v.exp_f2) : 32'(mf2));
  endtask

  initial begin
    vec_t v;
    //            rst frz fls vld s1 s2 two wb dst ld  hz mask      f1 f2
`ifdef REG_HAZARD_FORWARDING_EN
    tbl.push_back(mk(1,0,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 2,1, 0,15'h0004, 0,0));
    tbl.push_back(mk(0,0,0,1, 2,0,0,1, 7,0, 1,15'h0004, 0,0));
    tbl.push_back(mk(0,0,0,1, 2,0,0,1, 7,0, 0,15'h0080, 2,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 4,0, 0,15'h0090, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,4,1,1, 8,0, 0,15'h0110, 0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0100, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
`else
    tbl.push_back(mk(1,0,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 1,0, 0,15'h0002, 0,0));
    tbl.push_back(mk(0,0,0,1, 1,0,0,1, 5,0, 1,15'h0002, 0,0));
    tbl.push_back(mk(0,0,0,1, 1,0,0,1, 5,0, 1,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 1,0,0,1, 5,0, 0,15'h0020, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0020, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 3,0, 0,15'h0008, 0,0));
    tbl.push_back(mk(0,0,0,1, 7,8,1,0, 0,0, 0,15'h0008, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,3,1,0, 0,0, 1,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,3,1,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 3,0, 0,15'h0008, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,3,0,0, 0,0, 0,15'h0008, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1,14,0, 0,15'h4000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1,15,0, 0,15'h4000, 0,0));
    tbl.push_back(mk(0,0,0,1,15,15,1,0,0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 2,0, 0,15'h0004, 0,0));
    tbl.push_back(mk(0,0,0,1, 2,0,0,1, 6,0, 1,15'h0004, 0,0));
    tbl.push_back(mk(0,1,0,1, 2,0,0,1, 6,0, 0,15'h0004, 0,0));
    tbl.push_back(mk(0,1,0,1, 2,0,0,1, 6,0, 0,15'h0004, 0,0));
    tbl.push_back(mk(0,1,0,1, 2,0,0,1, 6,0, 0,15'h0004, 0,0));
    tbl.push_back(mk(0,0,0,1, 2,0,0,1, 6,0, 1,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 2,0,0,1, 6,0, 0,15'h0040, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0040, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 9,0, 0,15'h0200, 0,0));
    tbl.push_back(mk(0,0,1,1, 9,0,0,1,10,0, 1,15'h0200, 0,0));
    tbl.push_back(mk(0,0,1,1, 9,0,0,1,10,0, 1,15'h0000, 0,0));
    tbl.push_back(mk(0,0,1,1, 0,0,0,1,11,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 4,0, 0,15'h0010, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 4,0, 0,15'h0010, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0010, 0,0));
    tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 5,0, 0,15'h0020, 0,0));
    tbl.push_back(mk(0,0,0,1, 0,0,0,1, 6,0, 0,15'h0060, 0,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0,0, 0,0, 0,15'h0000, 0,0));
    tbl.push_back(mk(0,0,0,1, 5,6,1,0, 0,0, 0,15'h0000, 0,0));
`endif

    // Bring-up reset; the first table row re-applies reset with checks.
    rst = 1'b1;
    sb_if.freeze = 0; sb_if.flush = 0; sb_if.id_valid = 0;
    sb_if.id_src1 = 0; sb_if.id_src2 = 0; sb_if.id_two_src = 0;
    sb_if.id_wb_en = 0; sb_if.id_dest = 0; sb_if.id_mem_read = 0;
    repeat (2) @(posedge clk);
    #1;
    fly.delete(); adv = 0; mf1 = 2'b00; mf2 = 2'b00;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], 1'b1, $sformatf("row%0d", i));

    for (int i = 0; i < 1500; i++) begin
      v.rst = ($urandom_range(0, 49) == 0);
      v.frz = ($urandom_range(0, 6) == 0);
      v.fls = ($urandom_range(0, 9) == 0);
      v.vld = ($urandom_range(0, 4) != 0);
      v.s1  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      v.s2  = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      v.two = 1'($urandom_range(0, 1));
      v.wb  = ($urandom_range(0, 3) != 0);
      v.dst = ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
      v.ld  = ($urandom_range(0, 2) == 0);
      v.exp_hz = 1'b0; v.exp_mask = '0; v.exp_f1 = 2'b00; v.exp_f2 = 2'b00;
      run_vec(v, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
